// File: rtl/seq_detector_param.sv
// Moore serial pattern detector with a run-time programmable pattern and length,
// a selectable overlap policy, an input-valid qualifier and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned       PAT_W       = 8,
  parameter int unsigned       LEN_W       = 4,
  parameter int unsigned       CNT_W       = 8,
  parameter bit                OVERLAP     = 1'b1,
  parameter logic [PAT_W-1:0]  RST_PATTERN = PAT_W'(8'h0D),
  parameter int unsigned       RST_LEN     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic             in_bit_i,
  input  logic             cfg_load_i,
  input  logic [PAT_W-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             cnt_clr_i,
  output logic             match_o,
  output logic [CNT_W-1:0] match_count_o,
  output logic             armed_o
);

  localparam logic [LEN_W-1:0] PatWLen = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             armed;
  logic [PAT_W-1:0] hist_shift;
  logic [LEN_W-1:0] fill_inc;
  logic [PAT_W-1:0] len_mask;
  logic             detect;

  assign accept     = in_valid_i && !cfg_load_i;
  assign armed      = (len_q != '0);
  assign hist_shift = {hist_q[PAT_W-2:0], in_bit_i};
  assign fill_inc   = (fill_q >= PatWLen) ? PatWLen : fill_q + LEN_W'(1);

  // Only the low len bits of history and pattern take part in the comparison.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < int'(PAT_W); i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  assign detect = accept && armed && (fill_inc >= len_q) &&
                  (((hist_shift ^ pattern_q) & len_mask) == '0);

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
    cnt_d     = cnt_q;

    if (cfg_load_i) begin
      pattern_d = cfg_pattern_i;
      len_d     = (cfg_len_i > PatWLen) ? PatWLen : cfg_len_i;
      hist_d    = '0;
      fill_d    = '0;
    end else if (accept) begin
      hist_d  = hist_shift;
      fill_d  = (detect && !OVERLAP) ? '0 : fill_inc;
      match_d = detect;
    end

    // Clear wins over the old value but this cycle's detection still counts.
    if (cnt_clr_i) begin
      cnt_d = detect ? CNT_W'(1) : '0;
    end else if (detect && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= RST_PATTERN;
      len_q     <= LEN_W'(RST_LEN);
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
    end
  end

  assign match_o       = match_q;
  assign match_count_o = cnt_q;
  assign armed_o       = armed;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: three detector variants share one stimulus stream and are
// checked against a string-based reference model of the detection rules.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cnt_clr = 1'b0;

  logic       match_a, match_b, match_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic       armed_a, armed_b, armed_c;

  always #5 clk = ~clk;

  seq_detector_param #(.OVERLAP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_bit_i(in_bit),
    .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern), .cfg_len_i(cfg_len),
    .cnt_clr_i(cnt_clr), .match_o(match_a), .match_count_o(cnt_a), .armed_o(armed_a)
  );

  seq_detector_param #(.OVERLAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_bit_i(in_bit),
    .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern), .cfg_len_i(cfg_len),
    .cnt_clr_i(cnt_clr), .match_o(match_b), .match_count_o(cnt_b), .armed_o(armed_b)
  );

  seq_detector_param #(.OVERLAP(1'b1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_bit_i(in_bit),
    .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern), .cfg_len_i(cfg_len),
    .cnt_clr_i(cnt_clr), .match_o(match_c), .match_count_o(cnt_c), .armed_o(armed_c)
  );

  typedef struct packed {
    logic [2:0]      m;
    logic [2:0]      a;
    logic [2:0][7:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: accepted bits kept as a string, newest character last.
  string      m_hist[3];
  logic [7:0] m_pat[3];
  int         m_len[3];
  int         m_cnt[3];
  bit         m_match[3];
  int         m_ovl[3] = '{1, 0, 1};
  int         m_max[3] = '{255, 255, 3};

  function automatic string pat_str(input logic [7:0] p, input int len);
    string s = "";
    for (int i = len - 1; i >= 0; i--) s = {s, p[i] ? "1" : "0"};
    return s;
  endfunction

  task automatic model(input int k, input logic v, input logic b, input logic ld,
                       input logic [7:0] pat, input int len, input logic clr, input logic r);
    bit det = 0;
    if (r) begin
      m_pat[k] = 8'h0D; m_len[k] = 4; m_hist[k] = ""; m_cnt[k] = 0; m_match[k] = 0;
      return;
    end
    if (ld) begin
      m_pat[k] = pat; m_len[k] = (len > 8) ? 8 : len; m_hist[k] = "";
    end else if (v) begin
      m_hist[k] = {m_hist[k], b ? "1" : "0"};
      if (m_hist[k].len() > 8) m_hist[k] = m_hist[k].substr(1, m_hist[k].len() - 1);
      if (m_len[k] != 0 && m_hist[k].len() >= m_len[k] &&
          m_hist[k].substr(m_hist[k].len() - m_len[k], m_hist[k].len() - 1) ==
          pat_str(m_pat[k], m_len[k])) det = 1;
      if (det && m_ovl[k] == 0) m_hist[k] = "";
    end
    m_match[k] = det;
    if (clr) m_cnt[k] = det ? 1 : 0;
    else if (det && m_cnt[k] < m_max[k]) m_cnt[k]++;
  endtask

  task automatic step(input logic v, input logic b, input logic ld = 1'b0,
                      input logic [7:0] pat = 8'h00, input logic [3:0] len = 4'd0,
                      input logic clr = 1'b0, input logic r = 1'b0);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; in_bit = b; cfg_load = ld;
    cfg_pattern = pat; cfg_len = len; cnt_clr = clr;
    for (int k = 0; k < 3; k++) begin
      model(k, v, b, ld, pat, int'(len), clr, r);
      e.m[k] = m_match[k];
      e.a[k] = (m_len[k] != 0);
      e.c[k] = 8'(m_cnt[k]);
    end
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n, input int gap = 0);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i]);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0);
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are registered, so every cycle presents a new response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("match_a", int'(match_a), int'(e.m[0]));
        chk("match_b", int'(match_b), int'(e.m[1]));
        chk("match_c", int'(match_c), int'(e.m[2]));
        chk("count_a", int'(cnt_a), int'(e.c[0]));
        chk("count_b", int'(cnt_b), int'(e.c[1]));
        chk("count_c", int'(cnt_c), int'(e.c[2]));
        chk("armed_a", int'(armed_a), int'(e.a[0]));
        chk("armed_b", int'(armed_b), int'(e.a[1]));
        chk("armed_c", int'(armed_c), int'(e.a[2]));
      end
    end
  end

  initial begin
    int wait_cycles;
    step(1'b0, 1'b0, .r(1'b1));
    step(1'b0, 1'b0);
    // T1/T2: overlapping vs restarting history on 1101101
    send_bits(8'b0110_1101, 7);
    step(1'b0, 1'b0, .clr(1'b1));
    // T3: same stream with 3-cycle valid gaps
    step(1'b0, 1'b0, .r(1'b1));
    send_bits(8'b0110_1101, 7, 3);
    step(1'b0, 1'b0);
    // T4: 8-bit pattern, then a reload in the middle of a stream
    step(1'b0, 1'b0, 1'b1, 8'hA5, 4'd8);
    send_bits(8'hA5, 8);
    send_bits(8'hA5, 4);
    step(1'b1, 1'b1, 1'b1, 8'hA5, 4'd8);
    send_bits(8'hA5, 4);
    send_bits(8'hA5, 8);
    // T5: counter saturation on the 2-bit counter, then clear with a detection
    step(1'b0, 1'b0, 1'b1, 8'h0D, 4'd4);
    for (int i = 0; i < 5; i++) send_bits(8'h0D, 4);
    send_bits(8'h0D, 3);
    step(1'b1, 1'b1, .clr(1'b1));
    step(1'b0, 1'b0);
    // T6: reset mid-pattern, then a zero length
    send_bits(8'h0D, 3);
    step(1'b0, 1'b0, .r(1'b1));
    send_bits(8'h01, 1);
    step(1'b0, 1'b0, 1'b1, 8'h00, 4'd0);
    send_bits(8'h00, 8);
    send_bits(8'hFF, 8);
    // Single-bit pattern and an over-long length that clamps to 8
    step(1'b0, 1'b0, 1'b1, 8'h01, 4'd1);
    send_bits(8'b1101_0011, 8);
    step(1'b0, 1'b0, 1'b1, 8'hFF, 4'd15);
    send_bits(8'hFF, 8);
    send_bits(8'hFF, 3);
    // Random traffic with short random patterns
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0)
        step(1'($urandom), 1'($urandom), 1'b1, 8'($urandom), 4'($urandom_range(0, 9)));
      else if ($urandom_range(0, 199) == 0)
        step(1'b0, 1'b0, .r(1'b1));
      else
        step(1'($urandom_range(0, 3) != 0), 1'($urandom), .clr(1'($urandom_range(0, 49) == 0)));
    end
    step(1'b0, 1'b0);
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
